// File: rtl/seq_match_sched.sv
// rtl/seq_match_sched.sv - round-robin shared serial pattern-match engine
// Grants one requester's word, shifts it MSB-first through an overlapping matcher, returns the count.
module seq_match_sched #(
   parameter  int NREQ  = 4,
   parameter  int WIDTH = 8,
   parameter  int PLEN  = 4,
   localparam int IDW   = $clog2(NREQ),
   localparam int CW    = $clog2(WIDTH + 1)
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic [NREQ-1:0]         req_valid_i,
   input  logic [NREQ*WIDTH-1:0]   req_data_i,
   output logic [NREQ-1:0]         req_ready_o,
   input  logic [PLEN-1:0]         cfg_pattern_i,
   input  logic                    cfg_load_i,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [IDW-1:0]          rsp_id_o,
   output logic [CW-1:0]           rsp_count_o,
   output logic                    rsp_hit_o,
   output logic                    busy_o
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_RESP  = 2'd2;

   localparam logic [PLEN-1:0] PAT_RST = (PLEN == 4) ? PLEN'(4'b1011) : {PLEN{1'b1}};

   logic [1:0]       state_q, state_d;
   logic [IDW-1:0]   last_q, last_d;
   logic [IDW-1:0]   id_q, id_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [PLEN-1:0]  win_q, win_d;
   logic [PLEN-1:0]  pat_q, pat_d;
   logic [CW-1:0]    bitcnt_q, bitcnt_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             hit_q, hit_d;
   logic             valid_q, valid_d;

   logic [IDW-1:0]   grant;
   logic [IDW-1:0]   scan;
   logic             any_req;
   logic             accept;
   logic [PLEN-1:0]  win_nx;

   // Scan downward so the last hit written is the nearest one after last_q.
   always_comb begin
      grant   = last_q;
      scan    = '0;
      any_req = 1'b0;
      for (int k = NREQ; k >= 1; k--) begin
         scan = IDW'((int'(last_q) + k) % NREQ);
         if (req_valid_i[scan]) begin
            grant   = scan;
            any_req = 1'b1;
         end
      end
   end

   assign req_ready_o = (state_q == S_IDLE && any_req && !reset_i) ? (NREQ'(1) << grant) : '0;
   assign accept      = |(req_valid_i & req_ready_o);
   assign win_nx      = PLEN'({win_q, sh_q[WIDTH-1]});

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      id_d     = id_q;
      sh_d     = sh_q;
      win_d    = win_q;
      pat_d    = pat_q;
      bitcnt_d = bitcnt_q;
      cnt_d    = cnt_q;
      hit_d    = hit_q;
      valid_d  = valid_q;
      case (state_q)
         S_IDLE: begin
            if (cfg_load_i) pat_d = cfg_pattern_i;
            if (accept) begin
               state_d  = S_SHIFT;
               last_d   = grant;
               id_d     = grant;
               sh_d     = req_data_i[int'(grant)*WIDTH +: WIDTH];
               win_d    = '0;
               bitcnt_d = '0;
               cnt_d    = '0;
               hit_d    = 1'b0;
            end
         end
         S_SHIFT: begin
            sh_d     = sh_q << 1;
            win_d    = win_nx;
            bitcnt_d = bitcnt_q + CW'(1);
            // Window is only meaningful once PLEN bits of this word are in it.
            if ((int'(bitcnt_q) + 1 >= PLEN) && (win_nx == pat_q)) cnt_d = cnt_q + CW'(1);
            if (bitcnt_q == CW'(WIDTH - 1)) begin
               state_d = S_RESP;
               valid_d = 1'b1;
               hit_d   = (cnt_d != '0);
            end
         end
         S_RESP: begin
            if (rsp_ready_i) begin
               state_d = S_IDLE;
               valid_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= S_IDLE;
         last_q   <= IDW'(NREQ - 1);
         id_q     <= '0;
         sh_q     <= '0;
         win_q    <= '0;
         pat_q    <= PAT_RST;
         bitcnt_q <= '0;
         cnt_q    <= '0;
         hit_q    <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         id_q     <= id_d;
         sh_q     <= sh_d;
         win_q    <= win_d;
         pat_q    <= pat_d;
         bitcnt_q <= bitcnt_d;
         cnt_q    <= cnt_d;
         hit_q    <= hit_d;
         valid_q  <= valid_d;
      end
   end

   assign rsp_valid_o = valid_q;
   assign rsp_id_o    = id_q;
   assign rsp_count_o = cnt_q;
   assign rsp_hit_o   = hit_q;
   assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_seq_match_sched.sv
// tb/tb_seq_match_sched.sv - self-checking bench for seq_match_sched
// Transaction-level model scores each word by sliding-window search; compared every cycle.
module tb_seq_match_sched;
   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int PLEN  = 4;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic [PLEN-1:0]       cfg_pattern;
   logic                  cfg_load;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [1:0]            rsp_id;
   logic [3:0]            rsp_count;
   logic                  rsp_hit;
   logic                  busy;

   always #5 clk = ~clk;

   seq_match_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .PLEN(PLEN)) dut (
      .clk_i(clk), .reset_i(reset),
      .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready),
      .cfg_pattern_i(cfg_pattern), .cfg_load_i(cfg_load),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_id_o(rsp_id), .rsp_count_o(rsp_count), .rsp_hit_o(rsp_hit),
      .busy_o(busy)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int count_matches(input logic [WIDTH-1:0] w, input logic [PLEN-1:0] p);
      int c = 0;
      for (int i = 0; i <= WIDTH - PLEN; i++)
         if (w[WIDTH-1-i -: PLEN] == p) c++;
      return c;
   endfunction

   function automatic int pick(input int last, input logic [NREQ-1:0] v);
      for (int k = 1; k <= NREQ; k++)
         if (v[(last + k) % NREQ]) return (last + k) % NREQ;
      return -1;
   endfunction

   // Model: idle / bits remaining / response pending.
   int               m_left = 0;
   bit               m_resp = 0;
   int               m_last = NREQ - 1;
   int               m_id = 0;
   int               m_cnt = 0;
   logic [PLEN-1:0]  m_pat = 4'b1011;
   logic [WIDTH-1:0] m_word = '0;
   int               acc_log[$];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_left = 0; m_resp = 0; m_last = NREQ - 1; m_pat = 4'b1011;
      end else if (m_resp) begin
         if (rsp_ready) m_resp = 0;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin
            m_resp = 1;
            m_cnt  = count_matches(m_word, m_pat);
         end
      end else begin
         if (cfg_load) m_pat = cfg_pattern;
         if (|req_valid) begin
            m_id   = pick(m_last, req_valid);
            m_last = m_id;
            m_word = req_data[m_id*WIDTH +: WIDTH];
            m_left = WIDTH;
            acc_log.push_back(m_id);
         end
      end
   end

   logic [NREQ-1:0] exp_ready;
   always @(negedge clk) begin
      exp_ready = '0;
      if (!reset && !m_resp && m_left == 0 && |req_valid) exp_ready[pick(m_last, req_valid)] = 1'b1;
      check("req_ready", req_ready, exp_ready);
      check("busy", busy, (m_resp || m_left > 0));
      check("rsp_valid", rsp_valid, m_resp);
      if (m_resp) begin
         check("rsp_id", rsp_id, m_id);
         check("rsp_count", rsp_count, m_cnt);
         check("rsp_hit", rsp_hit, (m_cnt != 0));
      end
   end

   task automatic start(input int id, input logic [WIDTH-1:0] d, input bit ld, input logic [PLEN-1:0] p);
      @(posedge clk); #1;
      req_valid = '0;
      req_valid[id] = 1'b1;
      req_data[id*WIDTH +: WIDTH] = d;
      cfg_load = ld;
      cfg_pattern = p;
      @(posedge clk); #1;
      req_valid = '0;
      cfg_load = 1'b0;
   endtask

   task automatic finish(input string nm, input int id, input int exp, output int lat);
      int n = 0;
      while (rsp_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      lat = n;
      check({nm, "_wait"}, (n < 40), 1);
      check({nm, "_id"}, rsp_id, id);
      check({nm, "_count"}, rsp_count, exp);
      check({nm, "_hit"}, rsp_hit, (exp != 0));
   endtask

   task automatic drain();
      int n = 0;
      req_valid = '0;
      rsp_ready = 1'b1;
      while ((busy || rsp_valid) && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("drain", (n < 50), 1);
   endtask

   int lat;
   int n;

   initial begin
      reset = 1'b1; req_valid = 4'hF; req_data = '0;
      cfg_pattern = '0; cfg_load = 1'b0; rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_rsp_count", rsp_count, 0);
      check("rst_rsp_hit", rsp_hit, 0);
      req_valid = '0;
      reset = 1'b0;
      check("pin_1011", count_matches(8'b1011_0110, 4'b1011), 2);
      check("pin_ff", count_matches(8'hFF, 4'hF), 5);

      start(0, 8'b1011_0110, 0, '0);
      finish("basic", 0, 2, lat);
      check("latency", lat, WIDTH + 1);
      @(negedge clk);
      check("busy_after_rsp", busy, 0);
      drain();

      start(2, 8'b1011_1011, 0, '0);
      finish("overlap", 2, 2, lat);
      drain();
      @(posedge clk); #1 cfg_load = 1'b1; cfg_pattern = 4'b1111;
      @(posedge clk); #1 cfg_load = 1'b0;
      start(1, 8'hFF, 0, '0);
      finish("all_ones", 1, 5, lat);
      drain();
      start(3, 8'h00, 0, '0);
      finish("zero", 3, 0, lat);
      drain();

      // Round-robin straight out of reset.
      @(posedge clk); #1;
      reset = 1'b1;
      req_valid = 4'hF;
      req_data = {$urandom, $urandom};
      acc_log.delete();
      @(posedge clk); #1 reset = 1'b0;
      n = 0;
      while (acc_log.size() < 5 && n < 100) begin
         @(negedge clk);
         n++;
      end
      req_valid = '0;
      check("rr_count", (acc_log.size() >= 5), 1);
      if (acc_log.size() >= 5) begin
         check("rr_0", acc_log[0], 0);
         check("rr_1", acc_log[1], 1);
         check("rr_2", acc_log[2], 2);
         check("rr_3", acc_log[3], 3);
         check("rr_4", acc_log[4], 0);
      end
      drain();

      // Backpressure with competing requests pending.
      rsp_ready = 1'b0;
      start(1, 8'h5A, 0, '0);
      req_valid = 4'hF;
      finish("bp", 1, 1, lat);
      repeat (3) begin
         @(negedge clk);
         check("bp_valid", rsp_valid, 1);
         check("bp_id", rsp_id, 1);
         check("bp_count", rsp_count, 1);
         check("bp_no_ready", req_ready, 0);
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      drain();

      start(0, 8'b1011_0110, 0, '0);
      @(posedge clk); @(posedge clk); #1 cfg_load = 1'b1; cfg_pattern = 4'b0000;
      @(posedge clk); #1 cfg_load = 1'b0;
      finish("cfg_ignored", 0, 2, lat);
      drain();
      start(1, 8'hFF, 1, 4'b1111);
      finish("cfg_coincident", 1, 5, lat);
      drain();

      start(2, 8'hBB, 0, '0);
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      check("midrst_valid", rsp_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_ready", req_ready, 0);
      check("midrst_id", rsp_id, 0);
      check("midrst_count", rsp_count, 0);
      check("midrst_hit", rsp_hit, 0);
      @(posedge clk); #1 reset = 1'b0;
      n = 0;
      repeat (12) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0) n++;
      end
      check("midrst_no_rsp", n, 0);
      start(0, 8'b1011_0110, 0, '0);
      finish("post_rst_pattern", 0, 2, lat);
      drain();

      for (int i = 0; i < 500; i++) begin
         @(posedge clk); #1;
         req_valid   = NREQ'($urandom);
         req_data    = {$urandom, $urandom};
         rsp_ready   = ($urandom_range(0, 3) != 0);
         cfg_load    = ($urandom_range(0, 7) == 0);
         cfg_pattern = PLEN'($urandom);
      end
      @(posedge clk); #1;
      cfg_load = 1'b0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/seq_match_sched.md
# seq_match_sched

Round-robin scheduler that shares one serial pattern-match engine among `NREQ` requesters. Each requester submits a `WIDTH`-bit word over a valid/ready handshake. The block serializes the granted word MSB-first through an overlapping `PLEN`-bit pattern matcher and counts every match. It returns the count, tagged with the requester ID, over a response handshake. It sits between the per-lane word producers and the alarm/statistics logic.

## Interface
- `NREQ`, 4: number of requesters (≥2).
- `WIDTH`, 8: word length in bits (≥`PLEN`).
- `PLEN`, 4: pattern length in bits (≥1).
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  reset; asynchronous and active-high.
- `req_valid`  in  `NREQ`  request pending, one bit per requester.
- `req_data`  in  `NREQ*WIDTH`  requester i's word in bits [i*WIDTH +: WIDTH].
- `req_ready`  out  `NREQ`  one-hot accept strobe; a word is transferred when `req_valid[i] && req_ready[i]`.
- `cfg_pattern`  in  `PLEN`  new match pattern; bit [PLEN-1] is compared against the earliest bit.
- `cfg_load`  in  1  load `cfg_pattern` into the pattern register.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  `$clog2(NREQ)`  requester index of the response.
- `rsp_count`  out  `$clog2(WIDTH+1)`  number of pattern matches in the word.
- `rsp_hit`  out  1  `rsp_count != 0`.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states and transitions:
  - IDLE → SHIFT on accept.
  - SHIFT → RESP after `WIDTH` bit cycles.
  - RESP → IDLE on `rsp_valid && rsp_ready`.
- Arbitration, IDLE only:
  - The grant goes to the first `req_valid[i]` found searching from `last_grant+1`, wrapping modulo `NREQ`.
  - `req_ready` = one-hot(grant) combinationally while in IDLE with any `req_valid` high. It is all-zero in every other state.
  - `last_grant` updates to the granted index on accept.
- On accept:
  - Capture the word into the shift register and the ID into `rsp_id`.
  - Clear the window register, bit counter and match count.
- SHIFT, one bit per cycle, MSB first:
  - `window <= {window[PLEN-2:0], bit}`.
  - `bitcnt` increments.
  - A match is counted when at least `PLEN` bits of this word have been shifted in (including the current bit) and the updated window equals the pattern register.
- Matching is overlapping and confined to one word. Window state never carries between words.
- Pattern register:
  - Reset value is `PLEN'b1011` when `PLEN==4`, otherwise all ones.
  - Loads on `cfg_load` only while in IDLE. `cfg_load` in SHIFT or RESP is ignored, not deferred.
  - A `cfg_load` on the same edge as an accept applies to that word.
- RESP:
  - `rsp_valid`, `rsp_id`, `rsp_count` and `rsp_hit` are registered and held stable until `rsp_ready`.
  - No new grant is issued while in RESP.
- Maximum `rsp_count` = `WIDTH-PLEN+1`.

## Timing
- Reset values:
  - `rsp_valid`=0, `rsp_id`=0, `rsp_count`=0, `rsp_hit`=0, `busy`=0, `req_ready`=0.
  - FSM=IDLE, `last_grant`=`NREQ-1`, so the first grant after reset goes to requester 0.
- Latency:
  - Accept edge E0.
  - Bits processed on edges E1..E`WIDTH`.
  - `rsp_valid` is high after edge E`WIDTH`.
- With `rsp_ready` held high, the response completes at edge E`WIDTH+1`. The next accept can occur at edge E`WIDTH+2`.
- Sustained throughput is one word per `WIDTH+2` cycles.
- `busy` is high from after E0 until the response handshake edge.
- `req_valid` may drop without a handshake while in IDLE; arbitration re-evaluates each cycle.
- Reset asserted mid-SHIFT or mid-RESP:
  - All state returns to reset values immediately.
  - The in-flight word and its response are discarded; the requester must resubmit.

## Test plan
- Reset, pattern 1011, requester 0 submits 8'b1011_0110, `rsp_ready`=1 → `rsp_valid` after 8 shift edges with `rsp_id`=0, `rsp_count`=2, `rsp_hit`=1; `busy` low again one cycle later.
- Overlap: requester 2 submits 8'b1011_1011 → `rsp_count`=2. Load pattern 1111 in IDLE, then submit 8'hFF → `rsp_count`=5. Submit 8'h00 → `rsp_count`=0, `rsp_hit`=0.
- Round-robin: all four `req_valid` held high from reset → accepts in order 0,1,2,3,0. Each `req_ready` is one cycle wide and never overlaps `busy`.
- Backpressure: `rsp_ready` held low 3 cycles in RESP → `rsp_valid`, `rsp_id` and `rsp_count` are stable, and no `req_ready` is asserted until the handshake.
- Config guard: `cfg_load` with 0000 during SHIFT → ignored and the current word is scored with the old pattern. `cfg_load` coincident with an accept → new pattern applies to that word.
- Reset at shift edge 4 → outputs return to reset values immediately, no response is produced, and the pattern register returns to 1011.
